// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch vs loader/debug port on one sync SRAM.
// Optional anti-starvation counter enabled by IMEM_ARB_STARVE_EN.
module imem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t state, state_nx;
  logic   starve;

`ifdef IMEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt;

  assign starve = (cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (l_gnt || !l_req)
      cnt <= '0;
    else if (f_gnt)
      cnt <= cnt + 1'b1;
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ARB;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    if (!rst) begin
      unique case (state)
        ARB: begin
          if (starve) begin
            l_gnt = l_req;
          end else begin
            f_gnt = f_req;
            l_gnt = l_req && !f_req;
          end
          if (l_gnt && l_lock)
            state_nx = LOCK;
        end
        LOCK: begin
          l_gnt = l_req;
          if (!l_lock)
            state_nx = ARB;
        end
        default: state_nx = ARB;
      endcase
    end
  end

  // Loader wins the bus mux; grants are already mutually exclusive.
  always_comb begin
    m_en    = f_gnt || l_gnt;
    m_we    = l_gnt && l_we;
    m_addr  = '0;
    m_wdata = '0;
    if (l_gnt) begin
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end else if (f_gnt) begin
      m_addr  = f_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
    end else begin
      f_rvalid <= f_gnt;
      l_rvalid <= l_gnt && !l_we;
    end
  end

  assign f_rdata = f_rvalid ? m_rdata : 32'h0;
  assign l_rdata = l_rvalid ? m_rdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed + random bench for imem_arbiter with a grant/readback model.
// Honours IMEM_ARB_STARVE_EN the same way the design does.
module tb_imem_arbiter;
  localparam int AW = 6;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_gnt, f_rvalid;
  logic [31:0]   f_rdata;
  logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [AW-1:0] l_addr = '0;
  logic [31:0]   l_wdata = '0;
  logic          l_gnt, l_rvalid;
  logic [31:0]   l_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  always #5 clk = ~clk;

  imem_arbiter #(.STARVE_LIMIT(SL), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock),
    .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  logic [31:0] prog [4] = '{32'h00c00093, 32'h00500113,
                            32'h00208863, 32'h0020c863};
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] mem_q = 32'h0;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    for (int i = 0; i < 4; i++) begin
      mem[i]     = prog[i];
      ref_mem[i] = prog[i];
    end
  end

  // Synchronous single-port SRAM behind the arbiter
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      mem_q <= mem[m_addr];
    end
  end
  assign m_rdata = mem_q;

  int total  = 0;
  int passed = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Model: ownership rules in terms of a lock flag and a fetch streak
  bit          lk = 0;
  int          streak = 0;
  bit          ev_f = 0, ev_l = 0;
  logic [31:0] ed_f = 0, ed_l = 0;
  bit          eg_f = 0, eg_l = 0;
  bit          starve_on;

`ifdef IMEM_ARB_STARVE_EN
  assign starve_on = 1'b1;
`else
  assign starve_on = 1'b0;
`endif

  always @(negedge clk) begin
    eg_f = 0;
    eg_l = 0;
    if (!rst) begin
      if (lk) eg_l = l_req;
      else if (starve_on && streak >= SL) eg_l = l_req;
      else begin
        eg_f = f_req;
        eg_l = l_req && !f_req;
      end
    end
    check("f_gnt", 32'(f_gnt), 32'(eg_f));
    check("l_gnt", 32'(l_gnt), 32'(eg_l));
    check("m_en", 32'(m_en), 32'(eg_f | eg_l));
    check("m_we", 32'(m_we), 32'(eg_l & l_we));
    check("m_addr", 32'(m_addr),
          eg_l ? 32'(l_addr) : eg_f ? 32'(f_addr) : 32'h0);
    check("m_wdata", m_wdata, eg_l ? l_wdata : 32'h0);
    check("f_rvalid", 32'(f_rvalid), 32'(ev_f));
    check("l_rvalid", 32'(l_rvalid), 32'(ev_l));
    check("f_rdata", f_rdata, ev_f ? ed_f : 32'h0);
    check("l_rdata", l_rdata, ev_l ? ed_l : 32'h0);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lk = 0; streak = 0; ev_f = 0; ev_l = 0;
    end else begin
      ev_f = eg_f;
      ed_f = ref_mem[f_addr];
      ev_l = eg_l && !l_we;
      ed_l = ref_mem[l_addr];
      if (eg_l && l_we) ref_mem[l_addr] = l_wdata;
      if (!lk && eg_l && l_lock) lk = 1;
      else if (lk && !l_lock) lk = 0;
      if (eg_l || !l_req) streak = 0;
      else if (eg_f) streak++;
    end
  end

  task automatic drive(bit fr, logic [AW-1:0] fa, bit lr, bit lw,
                       bit ll, logic [AW-1:0] la, logic [31:0] wd);
    f_req = fr; f_addr = fa;
    l_req = lr; l_we = lw; l_lock = ll; l_addr = la; l_wdata = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 1, 0, 0, 5, 0);
    tick;
    #2 check("rst_f_gnt", 32'(f_gnt), 32'h0);
    check("rst_m_en", 32'(m_en), 32'h0);
    tick;
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    #2 check("first_gnt", 32'(f_gnt), 32'h1);
    tick;
    for (int i = 1; i < 4; i++) begin
      drive(1, AW'(i), 0, 0, 0, 0, 0);
      #2 check("prog_rv", 32'(f_rvalid), 32'h1);
      check("prog_data", f_rdata, prog[i-1]);
      tick;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 check("prog_data", f_rdata, 32'h0020c863);
    tick;

    for (int i = 0; i < 5; i++) begin
      drive(1, AW'(i + 8), 1, 0, 0, 5, 0);
`ifndef IMEM_ARB_STARVE_EN
      #2 check("prio_f", 32'(f_gnt), 32'h1);
      check("prio_l", 32'(l_gnt), 32'h0);
`endif
      tick;
    end
    drive(0, 0, 1, 0, 0, 5, 0);
    #2 check("l_gnt_free", 32'(l_gnt), 32'h1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 check("l_rd5", l_rdata, 32'hA500_0005);
    tick;

    drive(0, 0, 1, 1, 1, 10, 32'h4020d513);
    #2 check("lk_gnt", 32'(l_gnt), 32'h1);
    tick;
    drive(1, 1, 1, 1, 1, 11, 32'h4020d533);
    #2 check("lk_nof", 32'(f_gnt), 32'h0);
    check("wr_norv", 32'(l_rvalid), 32'h0);
    tick;
    drive(1, 1, 1, 1, 0, 12, 32'h0024e5b3);
    #2 check("lk_nof2", 32'(f_gnt), 32'h0);
    tick;
    drive(1, 11, 0, 0, 0, 0, 0);
    #2 check("unlk_f", 32'(f_gnt), 32'h1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 check("rd11", f_rdata, 32'h4020d533);
    tick;

    for (int i = 10; i < 13; i++) begin
      drive(0, 0, 1, 0, 0, AW'(i), 0);
      tick;
    end
    drive(0, 0, 0, 1, 1, 20, 32'h1);
    tick;
    drive(0, 0, 1, 1, 1, 20, 32'h1234_5678);
    tick;
    drive(1, 3, 0, 0, 1, 0, 0);
    #2 check("lk_idle", 32'(f_gnt), 32'h0);
    tick;
    drive(1, 3, 0, 0, 0, 0, 0);
    #2 check("lk_exit", 32'(f_gnt), 32'h0);
    tick;
    drive(1, 3, 0, 0, 0, 0, 0);
    #2 check("arb_back", 32'(f_gnt), 32'h1);
    tick;

`ifdef IMEM_ARB_STARVE_EN
    for (int i = 0; i < 15; i++) begin
      drive(1, AW'(i), 1, 0, 0, 7, 0);
      #2 check("starve", 32'(l_gnt), 32'((i % 5) == 4));
      tick;
    end
`endif

    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, AW'($urandom), $urandom);
      tick;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;

    drive(1, 2, 0, 0, 0, 0, 0);
    #2 check("pre_rst_f", 32'(f_gnt), 32'h1);
    #4 rst = 1'b1;
    tick;
    #2 check("rst_rv", 32'(f_rvalid), 32'h0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    #2 check("post_rst_rv", 32'(f_rvalid), 32'h0);
    tick;
    drive(0, 0, 1, 0, 1, 7, 0);
    tick;
    drive(0, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1, 4, 1, 0, 0, 7, 0);
    #2 check("rst_arb_f", 32'(f_gnt), 32'h1);
    check("rst_arb_l", 32'(l_gnt), 32'h0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
